yarp_decode_pipe: RTL

YARP_DECODE_PIPE -- requirements
Module: yarp_decode_pipe

---
 rtl/yarp_decode_pipe_if.sv | 41 ++++
 rtl/yarp_decode_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/yarp_decode_pipe_if.sv
// ============================================================================
// Module  : yarp_decode_pipe_if
// Brief   : Upstream instruction beat and downstream decoded-entry handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface yarp_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  pc_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic [4:0]       rd_o;
  logic [6:0]       op_o;
  logic [2:0]       funct3_o;
  logic [6:0]       funct7_o;
  logic [5:0]       type_o;
  logic [XLEN-1:0]  imm_o;
  logic             illegal_o;

  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, type_o, imm_o, illegal_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, type_o, imm_o, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/yarp_decode_pipe.sv
// ============================================================================
// Module  : yarp_decode_pipe
// Brief   : RV32 decode stage with a small FIFO of pre-decoded entries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module yarp_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              flush_i,
  yarp_decode_pipe_if.slave      bus,
  output logic [CNT_W-1:0]       dec_cnt_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      typ;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t              r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [CNT_W-1:0]    r_dec_cnt;

  logic                w_push;
  logic                w_pop;
  logic [5:0]          w_type;
  logic [31:0]         w_imm32;
  logic                w_illegal;
  entry_t              w_entry;
  entry_t              w_head;

  // Decode happens on the way in so each buffered slot holds ready-to-use fields.
  always_comb begin
    w_type    = 6'b000000;
    w_imm32   = 32'h0;
    w_illegal = 1'b0;
    case (bus.instr_i[6:0])
      7'b0110011: w_type = 6'b000001;
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_type  = 6'b000010;
        w_imm32 = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
      end
      7'b0100011: begin
        w_type  = 6'b000100;
        w_imm32 = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
      end
      7'b1100011: begin
        w_type  = 6'b001000;
        w_imm32 = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                   bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_type  = 6'b010000;
        w_imm32 = {bus.instr_i[31:12], 12'h000};
      end
      7'b1101111: begin
        w_type  = 6'b100000;
        w_imm32 = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                   bus.instr_i[20], bus.instr_i[30:21], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_entry         = '0;
    w_entry.pc      = bus.pc_i;
    w_entry.rs1     = bus.instr_i[19:15];
    w_entry.rs2     = bus.instr_i[24:20];
    w_entry.rd      = bus.instr_i[11:7];
    w_entry.op      = bus.instr_i[6:0];
    w_entry.funct3  = bus.instr_i[14:12];
    w_entry.funct7  = bus.instr_i[31:25];
    w_entry.typ     = w_type;
    w_entry.imm     = XLEN'($signed(w_imm32));
    w_entry.illegal = w_illegal;
  end

  assign bus.in_ready_o  = (r_count < (c_PTR_W + 1)'(DEPTH));
  assign bus.out_valid_o = (r_count != '0);
  assign w_push = bus.in_valid_i && bus.in_ready_o && !flush_i;
  assign w_pop  = bus.out_valid_o && bus.out_ready_i && !flush_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dec_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
        r_dec_cnt <= r_dec_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Push only happens below full, so the head slot is never overwritten while waiting.
  assign w_head        = r_mem[r_rd_ptr];
  assign bus.pc_o      = w_head.pc;
  assign bus.rs1_o     = w_head.rs1;
  assign bus.rs2_o     = w_head.rs2;
  assign bus.rd_o      = w_head.rd;
  assign bus.op_o      = w_head.op;
  assign bus.funct3_o  = w_head.funct3;
  assign bus.funct7_o  = w_head.funct7;
  assign bus.type_o    = w_head.typ;
  assign bus.imm_o     = w_head.imm;
  assign bus.illegal_o = w_head.illegal;
  assign dec_cnt_o     = r_dec_cnt;

endmodule

`default_nettype wire
